// File: rtl/alu_op_issuer.sv
// Issue-side ALU controller: decodes an accepted instruction into ALU op/operands,
// captures the ALU result one cycle later and hands it back over valid/ready.
module alu_op_issuer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [5:0]            Opcode,
    input  logic [5:0]            Funct,
    input  logic [4:0]            Shamt,
    input  logic [15:0]           Imm,
    input  logic [DATA_WIDTH-1:0] RsData,
    input  logic [DATA_WIDTH-1:0] RtData,
    output logic [3:0]            ALUControl,
    output logic [DATA_WIDTH-1:0] ALUA,
    output logic [DATA_WIDTH-1:0] ALUB,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  ALUZero,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  ZeroOut,
    output logic                  Illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    ill_q, ill_d;

    logic [3:0]              dec_ctrl;
    logic [DATA_WIDTH-1:0]   dec_a;
    logic [DATA_WIDTH-1:0]   dec_b;
    logic                    dec_ill;
    logic [DATA_WIDTH-1:0]   imm_sext;
    logic [DATA_WIDTH-1:0]   imm_zext;
    logic [DATA_WIDTH-1:0]   shamt_b;

    assign imm_sext = {{(DATA_WIDTH-16){Imm[15]}}, Imm};
    assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, Imm};
    // ALU takes the shift amount from B[10:6], mirroring the instruction layout
    assign shamt_b  = {{(DATA_WIDTH-11){1'b0}}, Shamt, 6'b0};

    always_comb begin
        dec_ctrl = 4'b0000;
        dec_a    = '0;
        dec_b    = '0;
        dec_ill  = 1'b0;
        case (Opcode)
            6'h00: begin
                dec_a = RsData;
                dec_b = RtData;
                case (Funct)
                    6'h20:   dec_ctrl = 4'b0010;
                    6'h22:   dec_ctrl = 4'b0110;
                    6'h24:   dec_ctrl = 4'b0000;
                    6'h25:   dec_ctrl = 4'b0001;
                    6'h27:   dec_ctrl = 4'b0011;
                    6'h2A:   dec_ctrl = 4'b0111;
                    6'h00: begin
                        dec_ctrl = 4'b1010;
                        dec_a    = RtData;
                        dec_b    = shamt_b;
                    end
                    default: begin
                        dec_ill = 1'b1;
                        dec_a   = '0;
                        dec_b   = '0;
                    end
                endcase
            end
            6'h1C: begin
                if (Funct == 6'h02) begin
                    dec_ctrl = 4'b1001;
                    dec_a    = RsData;
                    dec_b    = RtData;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            6'h08: begin dec_ctrl = 4'b0010; dec_a = RsData; dec_b = imm_sext; end
            6'h0A: begin dec_ctrl = 4'b0111; dec_a = RsData; dec_b = imm_sext; end
            6'h0C: begin dec_ctrl = 4'b0000; dec_a = RsData; dec_b = imm_zext; end
            6'h0D: begin dec_ctrl = 4'b0001; dec_a = RsData; dec_b = imm_zext; end
            6'h04: begin dec_ctrl = 4'b0110; dec_a = RsData; dec_b = RtData;   end
            6'h02: dec_ctrl = 4'b1000;
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    state_d = S_EXEC;
                    ctrl_d  = dec_ctrl;
                    a_d     = dec_a;
                    b_d     = dec_b;
                    ill_d   = dec_ill;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                // illegal ops report Result=0/Zero=1 regardless of what the ALU returns
                result_d = ill_q ? '0 : ALUResult;
                zero_d   = ill_q | ALUZero;
            end
            S_RESP: begin
                if (OutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'b0000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ill_q    <= ill_d;
        end
    end

    assign InReady    = (state_q == S_IDLE);
    assign OutValid   = (state_q == S_RESP);
    assign ALUControl = ctrl_q;
    assign ALUA       = a_q;
    assign ALUB       = b_q;
    assign Result     = result_q;
    assign ZeroOut    = zero_q;
    assign Illegal    = ill_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural 32-bit ALU attached.
module tb_alu_op_issuer;

    logic        Clk;
    logic        Rst;
    logic        InValid;
    logic        InReady;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [15:0] Imm;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [3:0]  ALUControl;
    logic [31:0] ALUA;
    logic [31:0] ALUB;
    logic [31:0] ALUResult;
    logic        ALUZero;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        ZeroOut;
    logic        Illegal;

    int unsigned total;
    int unsigned bad;

    alu_op_issuer #(.DATA_WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Shamt      (Shamt),
        .Imm        (Imm),
        .RsData     (RsData),
        .RtData     (RtData),
        .ALUControl (ALUControl),
        .ALUA       (ALUA),
        .ALUB       (ALUB),
        .ALUResult  (ALUResult),
        .ALUZero    (ALUZero),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Result     (Result),
        .ZeroOut    (ZeroOut),
        .Illegal    (Illegal)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        ALUResult = 32'h0;
        case (ALUControl)
            4'b0010: ALUResult = ALUA + ALUB;
            4'b0110: ALUResult = ALUA - ALUB;
            4'b0000: ALUResult = ALUA & ALUB;
            4'b0001: ALUResult = ALUA | ALUB;
            4'b0011: ALUResult = ~(ALUA | ALUB);
            4'b0111: ALUResult = ($signed(ALUA) < $signed(ALUB)) ? 32'h1 : 32'h0;
            4'b1010: ALUResult = ALUA << ALUB[10:6];
            4'b1001: ALUResult = ALUA * ALUB;
            default: ALUResult = 32'h0;
        endcase
        ALUZero = (ALUResult == 32'h0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
        Opcode = op; Funct = fn; Shamt = sh; Imm = im; RsData = rs; RtData = rt;
    endtask

    // One full transaction with OutReady high: accept, EXEC, RESP, back to IDLE.
    task automatic run_op(input string tag,
                          input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [3:0] e_ctrl, input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [31:0] e_res, input logic e_zero, input logic e_ill);
        drive(op, fn, sh, im, rs, rt);
        OutReady = 1'b1;
        InValid  = 1'b1;
        chk({tag, ".inready"}, {31'b0, InReady}, 32'h1);
        tick();
        InValid = 1'b0;
        chk({tag, ".ctrl"}, {28'b0, ALUControl}, {28'b0, e_ctrl});
        chk({tag, ".a"}, ALUA, e_a);
        chk({tag, ".b"}, ALUB, e_b);
        chk({tag, ".exec_ov"}, {31'b0, OutValid}, 32'h0);
        tick();
        chk({tag, ".ov"}, {31'b0, OutValid}, 32'h1);
        chk({tag, ".res"}, Result, e_res);
        chk({tag, ".zero"}, {31'b0, ZeroOut}, {31'b0, e_zero});
        chk({tag, ".ill"}, {31'b0, Illegal}, {31'b0, e_ill});
        tick();
        chk({tag, ".idle"}, {30'b0, OutValid, InReady}, 32'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'h0, 32'h0);
        tick();
        tick();
        Rst = 1'b0;
        chk("rst.inready", {31'b0, InReady}, 32'h1);
        chk("rst.ov", {31'b0, OutValid}, 32'h0);
        chk("rst.ctrl", {28'b0, ALUControl}, 32'h0);
        chk("rst.a", ALUA, 32'h0);
        chk("rst.b", ALUB, 32'h0);
        chk("rst.res", Result, 32'h0);
        chk("rst.zero", {30'b0, ZeroOut, Illegal}, 32'h0);

        //      tag     op     fn     sh    imm      rs            rt            ctrl     A             B             res           z     ill
        run_op("add",   6'h00, 6'h20, 5'd0, 16'h0,   32'd5,        32'd7,        4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0);
        run_op("addw",  6'h00, 6'h20, 5'd0, 16'h0,   32'hFFFFFFFF, 32'd1,        4'b0010, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0);
        run_op("sub",   6'h00, 6'h22, 5'd0, 16'h0,   32'd3,        32'd5,        4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("and",   6'h00, 6'h24, 5'd0, 16'h0,   32'hF0F0FFFF, 32'h0FF0000F, 4'b0000, 32'hF0F0FFFF, 32'h0FF0000F, 32'h00F0000F, 1'b0, 1'b0);
        run_op("or",    6'h00, 6'h25, 5'd0, 16'h0,   32'h00FF0000, 32'h000000F0, 4'b0001, 32'h00FF0000, 32'h000000F0, 32'h00FF00F0, 1'b0, 1'b0);
        run_op("nor",   6'h00, 6'h27, 5'd0, 16'h0,   32'h0,        32'h0,        4'b0011, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("slt",   6'h00, 6'h2A, 5'd0, 16'h0,   32'h80000000, 32'd1,        4'b0111, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0);
        run_op("sll",   6'h00, 6'h00, 5'd4, 16'h0,   32'h12345678, 32'd1,        4'b1010, 32'd1,        32'h00000100, 32'h10,       1'b0, 1'b0);
        run_op("mul",   6'h1C, 6'h02, 5'd0, 16'h0,   32'h00010000, 32'h00010000, 4'b1001, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 1'b0);
        run_op("addi",  6'h08, 6'h3F, 5'd0, 16'hFFFF, 32'd1,       32'h55,       4'b0010, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
        run_op("slti",  6'h0A, 6'h00, 5'd0, 16'h0001, 32'hFFFFFFFE, 32'h0,       4'b0111, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0, 1'b0);
        run_op("andi",  6'h0C, 6'h00, 5'd0, 16'h8F0F, 32'hFFFFFFFF, 32'h0,       4'b0000, 32'hFFFFFFFF, 32'h00008F0F, 32'h00008F0F, 1'b0, 1'b0);
        run_op("ori",   6'h0D, 6'h00, 5'd0, 16'h8000, 32'h0,       32'h0,        4'b0001, 32'h0,        32'h00008000, 32'h00008000, 1'b0, 1'b0);
        run_op("beqt",  6'h04, 6'h00, 5'd0, 16'h0,   32'hDEADBEEF, 32'hDEADBEEF, 4'b0110, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0);
        run_op("beqn",  6'h04, 6'h00, 5'd0, 16'h0,   32'hDEADBEEF, 32'h0,        4'b0110, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
        run_op("j",     6'h02, 6'h00, 5'd0, 16'h1234, 32'd9,       32'd9,        4'b1000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
        run_op("badfn", 6'h00, 6'h21, 5'd0, 16'h0,   32'd9,        32'd9,        4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1);
        run_op("badmf", 6'h1C, 6'h03, 5'd0, 16'h0,   32'd9,        32'd9,        4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1);

        // Illegal opcode held under backpressure, with a new instruction waiting.
        drive(6'h3F, 6'h20, 5'd0, 16'hFFFF, 32'd11, 32'd22);
        OutReady = 1'b0;
        InValid  = 1'b1;
        tick();
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd100, 32'd23);
        chk("bp.ctrl", {28'b0, ALUControl}, 32'h0);
        chk("bp.ab", ALUA | ALUB, 32'h0);
        chk("bp.exec_inready", {31'b0, InReady}, 32'h0);
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            chk("bp.ov", {31'b0, OutValid}, 32'h1);
            chk("bp.inready", {31'b0, InReady}, 32'h0);
            chk("bp.ill", {31'b0, Illegal}, 32'h1);
            chk("bp.res", Result, 32'h0);
            chk("bp.zero", {31'b0, ZeroOut}, 32'h1);
            chk("bp.held_ctrl", {28'b0, ALUControl}, 32'h0);
            tick();
        end
        OutReady = 1'b1;
        chk("bp.ov_last", {31'b0, OutValid}, 32'h1);
        tick();
        chk("bp.release", {30'b0, OutValid, InReady}, 32'h1);
        chk("bp.not_taken", {28'b0, ALUControl}, 32'h0);
        tick();
        InValid = 1'b0;
        chk("bp.next_ctrl", {28'b0, ALUControl}, 32'h2);
        chk("bp.next_a", ALUA, 32'd100);
        tick();
        chk("bp.next_res", Result, 32'd123);
        chk("bp.next_ill", {31'b0, Illegal}, 32'h0);
        tick();

        // Reset during EXEC of MUL 3*4 discards the transaction.
        drive(6'h1C, 6'h02, 5'd0, 16'h0, 32'd3, 32'd4);
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk("rx.ctrl", {28'b0, ALUControl}, 32'h9);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("rx.ov", {31'b0, OutValid}, 32'h0);
        chk("rx.inready", {31'b0, InReady}, 32'h1);
        chk("rx.ctrl0", {28'b0, ALUControl}, 32'h0);
        chk("rx.ab", ALUA | ALUB, 32'h0);
        chk("rx.res", Result, 32'h0);
        chk("rx.flags", {30'b0, ZeroOut, Illegal}, 32'h0);
        tick();
        chk("rx.no_pulse", {31'b0, OutValid}, 32'h0);

        // Reset and InValid together: nothing accepted.
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7);
        Rst = 1'b1;
        InValid = 1'b1;
        tick();
        Rst = 1'b0;
        InValid = 1'b0;
        chk("ri.inready", {31'b0, InReady}, 32'h1);
        chk("ri.ctrl", {28'b0, ALUControl}, 32'h0);
        tick();
        chk("ri.ov", {31'b0, OutValid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Issue-side controller for the 32-bit ALU: accepts a decoded instruction (opcode, funct, shamt, register operands, immediate) over a valid/ready handshake and selects the 4-bit ALU operation code. It forms and registers the A/B operands, drives them into the combinational ALU, and captures the ALU's result and zero flag. It returns them to the execute stage over a second valid/ready handshake. It sits between the instruction-decode stage and the ALU in the multi-cycle datapath.

## Interface
- Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- Ports:
- Clk  in  1  single clock; all state on rising edge.
- Rst  in  1  synchronous, active-high reset.
- InValid  in  1  instruction/operands valid.
- InReady  out  1  issuer can accept; equals (state == IDLE).
- Opcode  in  6  instruction bits [31:26].
- Funct  in  6  instruction bits [5:0].
- Shamt  in  5  instruction bits [10:6].
- Imm  in  16  instruction bits [15:0].
- RsData  in  32  rs register value.
- RtData  in  32  rt register value.
- ALUControl  out  4  to ALU operation select (registered).
- ALUA  out  32  to ALU A (registered).
- ALUB  out  32  to ALU B (registered).
- ALUResult  in  32  from ALU.
- ALUZero  in  1  from ALU.
- OutValid  out  1  Result/ZeroOut/Illegal valid.
- OutReady  in  1  consumer accepts.
- Result  out  32  captured ALU result.
- ZeroOut  out  1  captured zero flag (beq taken when 1).
- Illegal  out  1  opcode/funct not decodable.

## Operation
- Decode on acceptance (InValid & InReady); ALUControl/ALUA/ALUB latched the same edge:
- Opcode 0x00: funct 0x20 ADD 0010, 0x22 SUB 0110, 0x24 AND 0000, 0x25 OR 0001, 0x27 NOR 0011, 0x2A SLT 0111; A=RsData, B=RtData.
- Opcode 0x00, funct 0x00 SLL 1010: A=RtData, B={21'b0, Shamt, 6'b0} (ALU shifts by B[10:6]).
- Opcode 0x1C, funct 0x02 MUL 1001: A=RsData, B=RtData; low 32 bits of product.
- Opcode 0x08 ADDI 0010, 0x0A SLTI 0111: A=RsData, B=sign-extended Imm.
- Opcode 0x0C ANDI 0000, 0x0D ORI 0001: A=RsData, B=zero-extended Imm.
- Opcode 0x04 BEQ 0110: A=RsData, B=RtData; ZeroOut=1 means taken.
- Opcode 0x02 J 1000: A=B=0.
- Anything else: Illegal=1, ALUControl 0000, ALUA=ALUB=0; the transaction still completes with Result=0, ZeroOut=1.
- FSM: IDLE -> EXEC on acceptance; EXEC -> RESP unconditionally (Result<=ALUResult, ZeroOut<=ALUZero captured at end of EXEC); RESP -> IDLE when OutReady.
- OutValid = (state == RESP); Result/ZeroOut/Illegal held stable while OutValid & !OutReady.
- ALUControl/ALUA/ALUB hold their last values outside EXEC; no new value until next acceptance.
- Arithmetic wrap: ADD/SUB/ADDI/MUL are modulo 2^32, no overflow trap.

## Timing
- Reset (Rst=1 at an edge): state=IDLE, ALUControl=0000, ALUA=ALUB=0, Result=0, ZeroOut=0, Illegal=0, OutValid=0; InReady=1 the cycle after reset.
- Accept at edge k; ALU ports valid after k; Result captured at edge k+1; OutValid=1 after edge k+1.
- Minimum 3 cycles per instruction (IDLE, EXEC, RESP with OutReady=1); back-to-back acceptance occurs at the edge after RESP handshake.
- InValid while not IDLE: ignored (InReady=0); source must hold.
- OutReady low: stay in RESP indefinitely; outputs stable.
- Rst mid-EXEC or mid-RESP: transaction discarded, no OutValid pulse, reset values next cycle.
- Rst and InValid simultaneous: reset wins, nothing accepted.

## Test plan
- ADD: RsData=5, RtData=7, Opcode 0, Funct 0x20 -> ALUControl=0010, Result=12, ZeroOut=0, OutValid 2 cycles after accept.
- BEQ: Rs=Rt=0xDEADBEEF, Opcode 0x04 -> ALUControl=0110, Result=0, ZeroOut=1; Rt=0 -> ZeroOut=0.
- Immediate extension: ADDI Rs=1, Imm=0xFFFF -> B=0xFFFFFFFF, Result=0, ZeroOut=1; ORI Rs=0, Imm=0x8000 -> Result=0x00008000.
- SLL Rt=1, Shamt=4 -> ALUB=0x00000100, Result=0x10; SLTI Rs=0xFFFFFFFE, Imm=1 -> Result=1.
- Backpressure/illegal: Opcode 0x3F with OutReady low 5 cycles -> Illegal=1, Result=0, ZeroOut=1 held, InReady=0 throughout; accepted next instruction only after handshake.
- Reset in EXEC of MUL 3*4 -> no OutValid, all outputs reset values, InReady=1 the following cycle.
